// File: rtl/addend_align_shifter.sv
// addend_align_shifter
// Multi-precision addend alignment shifter for the MAF datapath. Loads the
// addend mantissa into a lane-partitioned alignment register (one full lane
// or two half lanes). Each lane then shifts right by its own saturated amount,
// at most STEP bits per cycle. Bits shifted out fold into the lane's sticky bit.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (in_ready is combinational from out_ready)
//   mode                   00 full, 01 dual-half, 10 full bypass, 11 invalid
//   mant                   addend mantissa
//   shamt0 / shamt1        right-shift amounts (full or lane0 / dual lane1)
//   out_valid / out_ready  result handshake
//   sh_reg                 aligned addend; per lane bit1 = guard, bit0 = sticky
//   mode_err               last accepted request had mode 11
//   busy                   shifting in progress
module addend_align_shifter #(
    parameter int unsigned DW   = 76,
    parameter int unsigned MW   = 24,
    parameter int unsigned HW   = 11,
    parameter int unsigned SHW  = 7,
    parameter int unsigned STEP = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     mode,
    input  logic [MW-1:0]  mant,
    input  logic [SHW-1:0] shamt0,
    input  logic [SHW-1:0] shamt1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  sh_reg,
    output logic           mode_err,
    output logic           busy
);

    localparam int unsigned HL = DW / 2;
    localparam int unsigned HPAD = HL - 1 - HW;
    localparam logic [SHW-1:0] LEN_FULL = SHW'(DW);
    localparam logic [SHW-1:0] LEN_HALF = SHW'(HL);
    localparam logic [SHW-1:0] STEP_K   = SHW'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state;
    logic [SHW-1:0] rem0;
    logic [SHW-1:0] rem1;
    logic           dual;

    // Clamp a shift amount to the lane length.
    function automatic logic [SHW-1:0] sat(input logic [SHW-1:0] s, input logic [SHW-1:0] lim);
        return (s > lim) ? lim : s;
    endfunction

    // One step on the full lane: shift right by k, bit0 collects old[k:0].
    function automatic logic [DW-1:0] step_full(input logic [DW-1:0] v, input logic [SHW-1:0] k);
        logic [DW-1:0] r;
        logic          st;
        r  = v >> k;
        st = 1'b0;
        for (int i = 0; i < int'(DW); i++) begin
            if (i <= int'(k)) st = st | v[i];
        end
        r[0] = st;
        return r;
    endfunction

    // Same step on a half lane, so nothing crosses the lane boundary.
    function automatic logic [HL-1:0] step_half(input logic [HL-1:0] v, input logic [SHW-1:0] k);
        logic [HL-1:0] r;
        logic          st;
        r  = v >> k;
        st = 1'b0;
        for (int i = 0; i < int'(HL); i++) begin
            if (i <= int'(k)) st = st | v[i];
        end
        r[0] = st;
        return r;
    endfunction

    logic accept;
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Load image and saturated shift amounts for the incoming request.
    logic [DW-1:0]  load_val;
    logic [SHW-1:0] load_s0;
    logic [SHW-1:0] load_s1;
    logic           load_shift;

    always_comb begin
        load_val = '0;
        load_s0  = '0;
        load_s1  = '0;
        case (mode)
            2'b00: begin
                load_val = {mant, {(DW-MW){1'b0}}};
                load_s0  = sat(shamt0, LEN_FULL);
            end
            2'b01: begin
                load_val = {1'b0, mant[2*HW-1:HW], {HPAD{1'b0}},
                            1'b0, mant[HW-1:0],    {HPAD{1'b0}}};
                load_s0  = sat(shamt0, LEN_HALF);
                load_s1  = sat(shamt1, LEN_HALF);
            end
            2'b10:   load_val = {mant, {(DW-MW){1'b0}}};
            default: load_val = '0;
        endcase
        load_shift = (load_s0 != '0) | (load_s1 != '0);
    end

    // Per-cycle step amounts and the stepped register image.
    logic [SHW-1:0] k0, k1, rem0_n, rem1_n;
    logic [DW-1:0]  step_val;

    always_comb begin
        k0     = (rem0 > STEP_K) ? STEP_K : rem0;
        k1     = (rem1 > STEP_K) ? STEP_K : rem1;
        rem0_n = rem0 - k0;
        rem1_n = rem1 - k1;
        if (dual) step_val = {step_half(sh_reg[DW-1:HL], k1), step_half(sh_reg[HL-1:0], k0)};
        else      step_val = step_full(sh_reg, k0);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            sh_reg    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mode_err  <= 1'b0;
            rem0      <= '0;
            rem1      <= '0;
            dual      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        sh_reg   <= load_val;
                        mode_err <= (mode == 2'b11);
                        dual     <= (mode == 2'b01);
                        if (load_shift) begin
                            state     <= SHIFT;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            rem0      <= load_s0;
                            rem1      <= load_s1;
                        end else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            rem0      <= '0;
                            rem1      <= '0;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    sh_reg <= step_val;
                    rem0   <= rem0_n;
                    rem1   <= rem1_n;
                    if ((rem0_n == '0) && (rem1_n == '0)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addend_align_shifter.sv
// Self-checking bench for addend_align_shifter: directed steps with a
// scoreboard queue of expected results produced by a one-shot shift model.
module tb_addend_align_shifter;

    localparam int unsigned DW   = 76;
    localparam int unsigned MW   = 24;
    localparam int unsigned HW   = 11;
    localparam int unsigned SHW  = 7;
    localparam int unsigned STEP = 16;
    localparam int unsigned HL   = DW / 2;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     mode = 2'b00;
    logic [MW-1:0]  mant = '0;
    logic [SHW-1:0] shamt0 = '0;
    logic [SHW-1:0] shamt1 = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  sh_reg;
    logic           mode_err;
    logic           busy;

    addend_align_shifter #(.DW(DW), .MW(MW), .HW(HW), .SHW(SHW), .STEP(STEP)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .mant(mant), .shamt0(shamt0), .shamt1(shamt1),
        .out_valid(out_valid), .out_ready(out_ready), .sh_reg(sh_reg),
        .mode_err(mode_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] sh;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Whole shift in one go: value >> s, bit0 = OR of original bits [s:0].
    function automatic logic [DW-1:0] shr_lane(input logic [DW-1:0] v, input int s);
        logic [DW-1:0] r;
        logic          st;
        if (s == 0) return v;
        r  = v >> s;
        st = 1'b0;
        for (int i = 0; i < int'(DW); i++) if (i <= s) st = st | v[i];
        r[0] = st;
        return r;
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic [MW-1:0] mv,
                                   input int s0, input int s1);
        exp_t          e;
        int            a0, a1, mx;
        logic [DW-1:0] full, r1, r0;
        logic [HL-1:0] l1, l0;
        full  = DW'(mv) << (DW - MW);
        e.err = (m == 2'b11);
        e.lat = 1;
        e.sh  = '0;
        case (m)
            2'b00: begin
                a0   = (s0 > int'(DW)) ? int'(DW) : s0;
                e.sh = shr_lane(full, a0);
                if (a0 > 0) e.lat = 1 + (a0 + int'(STEP) - 1) / int'(STEP);
            end
            2'b01: begin
                a0 = (s0 > int'(HL)) ? int'(HL) : s0;
                a1 = (s1 > int'(HL)) ? int'(HL) : s1;
                l1 = HL'(mv[2*HW-1:HW]) << (HL - 1 - HW);
                l0 = HL'(mv[HW-1:0]) << (HL - 1 - HW);
                r1 = shr_lane(DW'(l1), a1);
                r0 = shr_lane(DW'(l0), a0);
                e.sh = {r1[HL-1:0], r0[HL-1:0]};
                mx = (a0 > a1) ? a0 : a1;
                if (mx > 0) e.lat = 1 + (mx + int'(STEP) - 1) / int'(STEP);
            end
            2'b10:   e.sh = full;
            default: e.sh = '0;
        endcase
        return e;
    endfunction

    // Present a request at +1 after an edge; returns at +1 after the accept edge.
    task automatic do_accept(input logic [1:0] m, input logic [MW-1:0] mv, input int s0, input int s1);
        mode = m; mant = mv; shamt0 = SHW'(s0); shamt1 = SHW'(s1);
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_at_accept", DW'(in_ready), DW'(1));
        sbq.push_back(model(m, mv, s0, s1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and compare against the scoreboard head.
    task automatic collect(input string tag);
        int   lat = 1;
        int   bc  = 0;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_valid"}, DW'(out_valid), DW'(1));
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, DW'(0), DW'(1));
        end else begin
            e = sbq.pop_front();
            check({tag, "_sh"}, sh_reg, e.sh);
            check({tag, "_err"}, DW'(mode_err), DW'(e.err));
            check({tag, "_lat"}, DW'(lat), DW'(e.lat));
            check({tag, "_busy_cycles"}, DW'(bc), DW'(e.lat - 1));
        end
    endtask

    // Let the result be taken with no new request behind it.
    task automatic consume(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_taken"}, DW'(out_valid), DW'(0));
    endtask

    logic [DW-1:0] held;
    logic [DW-1:0] cst;

    initial begin
        #2;
        check("rst_sh", sh_reg, '0);
        check("rst_valid", DW'(out_valid), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_err", DW'(mode_err), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", DW'(in_ready), DW'(1));

        // Full, no shift
        do_accept(2'b00, 24'hFFFFFF, 0, 0);
        collect("full_s0");
        cst = {24'hFFFFFF, 52'd0};
        check("full_s0_const", sh_reg, cst);
        consume("full_s0");

        // Full, shift 60: bit75 -> 15, bit52 -> sticky
        do_accept(2'b00, 24'h800001, 60, 0);
        collect("full_s60");
        cst = 76'h8001;
        check("full_s60_const", sh_reg, cst);
        consume("full_s60");

        // Dual, lane1 saturates at 38
        do_accept(2'b01, {2'b00, 11'h7FF, 11'h001}, 3, 40);
        collect("dual_sat");
        cst = (76'd1 << 38) | (76'd1 << 23);
        check("dual_sat_const", sh_reg, cst);
        consume("dual_sat");

        // Backpressure in DONE, then back-to-back accept
        out_ready = 1'b0;
        do_accept(2'b00, 24'hABCDEF, 20, 0);
        collect("bp_first");
        held = sh_reg;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", DW'(out_valid), DW'(1));
            check("bp_hold_sh", sh_reg, held);
            check("bp_hold_in_ready", DW'(in_ready), DW'(0));
        end
        out_ready = 1'b1;
        mode = 2'b01; mant = 24'h123456; shamt0 = 7'd5; shamt1 = 7'd17;
        in_valid = 1'b1;
        #1;
        check("b2b_in_ready", DW'(in_ready), DW'(1));
        sbq.push_back(model(2'b01, 24'h123456, 5, 17));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_drop", DW'(out_valid), DW'(0));
        collect("b2b");
        consume("b2b");

        // Invalid mode, then bypass clears mode_err
        do_accept(2'b11, 24'h5A5A5A, 9, 0);
        collect("mode11");
        check("mode11_err_const", DW'(mode_err), DW'(1));
        consume("mode11");
        do_accept(2'b10, 24'h5A5A5A, 50, 0);
        collect("mode10");
        consume("mode10");

        // Mixed requests
        for (int i = 0; i < 8; i++) begin
            do_accept(2'($urandom_range(0, 3)), MW'($urandom), int'($urandom_range(0, 127)),
                      int'($urandom_range(0, 127)));
            collect("rand");
            consume("rand");
        end

        // Reset during the second SHIFT cycle
        do_accept(2'b00, 24'hFFFFFF, 76, 0);
        @(posedge clk);
        #1;
        check("mid_busy", DW'(busy), DW'(1));
        rstn = 1'b0;
        #1;
        sbq.delete();
        check("mid_rst_sh", sh_reg, '0);
        check("mid_rst_valid", DW'(out_valid), DW'(0));
        check("mid_rst_busy", DW'(busy), DW'(0));
        check("mid_rst_err", DW'(mode_err), DW'(0));
        check("mid_rst_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post_mid_rst_valid", DW'(out_valid), DW'(0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addend_align_shifter.md
# addend_align_shifter

Parametrised multi-precision addend alignment shifter for the MAF datapath. It loads the addend mantissa into a lane-partitioned alignment register according to precision mode. It then right-shifts each lane independently by its own alignment amount, STEP bits per cycle, folding shifted-out bits into a per-lane sticky bit. It sits between exponent-difference logic and the 3:2 compressor/adder stage, with valid/ready handshakes on both sides.

## Interface
- DW, 76: alignment register width; must be even.
- MW, 24: full-precision mantissa width.
- HW, 11: half-precision mantissa width; HW+3 ≤ DW/2.
- SHW, 7: shift-amount width.
- STEP, 16: maximum shift applied per cycle per lane.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready.
- mode  in  2  00 full, 01 dual-half, 10 full bypass (no shift), 11 invalid.
- mant  in  MW  addend mantissa; dual mode uses lane1=mant[2HW-1:HW], lane0=mant[HW-1:0]; other bits ignored.
- shamt0  in  SHW  right-shift amount, full lane or dual lane0.
- shamt1  in  SHW  right-shift amount, dual lane1; ignored otherwise.
- out_valid  out  1  sh_reg holds a finished result.
- out_ready  in  1  consumer takes result when out_valid&out_ready.
- sh_reg  out  DW  aligned addend; per lane, bit1=guard and bit0=sticky.
- mode_err  out  1  last accepted request had mode 11.
- busy  out  1  state is SHIFT.

## Operation
- Layouts at load:
  - Full and bypass: one lane of width L=DW. mant goes to [DW-1:DW-MW]; all other bits are 0.
  - Dual: lane1=[DW-1:DW/2] and lane0=[DW/2-1:0], each of width L=DW/2. In each lane, the top bit is 0, the mantissa sits in the next HW bits, and the rest is 0.
  - Invalid: sh_reg is all 0 and mode_err is 1.
- Shift amounts are saturated to L at accept. The remaining count per lane is held in internal registers.
- Shift step: each SHIFT cycle, each lane shifts right by k = min(remaining, STEP).
  - new[L-1:0] = old >> k.
  - new[0] = |old[k:0]. A lane with k=0 is unchanged.
  - No bit ever crosses a lane boundary.
  - remaining -= k.
- States: IDLE, SHIFT, DONE.
  - IDLE: on accept, load sh_reg. Go to SHIFT if any saturated amount > 0 and mode is 00 or 01; otherwise go to DONE.
  - SHIFT: step every cycle. Go to DONE in the cycle where all remaining counts reach 0.
  - DONE: out_valid=1, and sh_reg and mode_err are held stable. On out_valid&out_ready:
    - with no simultaneous accept, go to IDLE;
    - with a simultaneous accept, load the new request and branch as from IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from out_ready.
- mode_err updates only on accept.
- Invalid mode is accepted, not dropped.

## Timing
- Reset (asynchronous, immediate):
  - sh_reg=0, out_valid=0, mode_err=0, busy=0.
  - State=IDLE, remaining counts=0.
  - in_ready=1 while in reset and after release.
- Latency from the accept edge to the out_valid edge is 1+ceil(max(sat0,sat1)/STEP) cycles, where sat0 and sat1 are the saturated amounts.
  - Bypass, invalid and zero-shift requests: 1 cycle.
  - Worst case with defaults: full mode ceil(76/16)+1=6; dual mode ceil(38/16)+1=4.
- Throughput with out_ready held high is one result per latency period, with no bubble cycle between results.
- Backpressure: while out_ready=0 in DONE, all outputs hold indefinitely and in_ready=0.
- Reset mid-SHIFT or mid-DONE discards the result. No partial output is ever flagged valid.

## Test plan
- Full, shamt0=0. Stimulus: mant=24'hFFFFFF, accept at cycle T. Required: out_valid at T+1, sh_reg={24'hFFFFFF,52'b0}, mode_err=0.
- Full, shamt0=60. Stimulus: mant=24'h800001. Required: busy for 4 cycles, out_valid at T+5, sh_reg with only bits 15 and 0 set.
- Dual with saturation. Stimulus: lane1=11'h7FF, lane0=11'h001, shamt1=40 (saturates to 38), shamt0=3. Required: out_valid at T+4, sh_reg with only bit 38 (lane1 sticky) and bit 23 set, no cross-lane bleed.
- Backpressure and back-to-back. Hold out_ready=0 for 5 cycles in DONE. Required during the hold: sh_reg and out_valid stable, in_ready=0. Then raise out_ready with in_valid=1. Required: in the same cycle in_ready=1 and the new request is loaded, and out_valid drops for exactly its latency minus 1 cycles.
- Mode 11, then mode 10. Mode 11 stimulus: shamt0=9. Required: sh_reg=0, mode_err=1, out_valid at T+1. Mode 10 stimulus: shamt0=50. Required: sh_reg equals the unshifted full layout, latency 1, and mode_err clears.
- Reset mid-SHIFT. Assert rstn=0 during the second SHIFT cycle of a full, shamt0=76 request. Required: all outputs 0 immediately, in_ready=1, and no out_valid pulse after release.
